// File: rtl/pll_sup_pkg.sv
// Shared state codes and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Width of the shared phase counter: enough for the largest count minus one.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous clear to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor producing a held-off downstream reset.
// Optional RUN-state glitch filter: define PLL_SUP_GLITCH_FILTER_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GLITCH_CYCLES  = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pll_locked_i,
  output logic             pll_rst_o,
  output logic             rst_out_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] relock_count_o,
  output logic [CNT_W-1:0] timeout_count_o,
  output logic [1:0]       state_o
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, GLITCH_CYCLES);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             locked_s;
  logic             loss_s;
  logic             tmo_evt_s;
  logic             relock_evt_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

`ifdef PLL_SUP_GLITCH_FILTER_EN
  // In RUN the phase counter doubles as the low-persistence counter.
  assign loss_s = !locked_s && (cnt_q == CW'(GLITCH_CYCLES - 1));
`else
  assign loss_s = !locked_s;
`endif

  // State, phase counter and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      relock_q  <= '0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      relock_q  <= relock_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and phase-counter logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    tmo_evt_s    = 1'b0;
    relock_evt_s = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT;
        else                                  state_d = ST_PLLRST;
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = ST_PLLRST;
          tmo_evt_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STABLE: begin
        if (!locked_s)                              state_d = ST_WAIT;
        else if (cnt_q == CW'(STABLE_CYCLES - 1))   state_d = ST_RUN;
        else                                        state_d = ST_STABLE;
      end
      ST_RUN: begin
        if (loss_s) begin
          state_d      = ST_PLLRST;
          relock_evt_s = 1'b1;
        end else if (!locked_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_d;
  end

  // Outputs follow the next state so they change on the entering edge
  always_comb begin
    pll_rst_d = (state_d == ST_PLLRST);
    rst_out_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    if (relock_evt_s) relock_d = CNT_W'(sat_inc(32'(relock_q), CNT_MAX));
    else              relock_d = relock_q;
    if (tmo_evt_s)    timeout_d = CNT_W'(sat_inc(32'(timeout_q), CNT_MAX));
    else              timeout_d = timeout_q;
  end

  assign pll_rst_o       = pll_rst_q;
  assign rst_out_o       = rst_out_q;
  assign ready_o         = ready_q;
  assign relock_count_o  = relock_q;
  assign timeout_count_o = timeout_q;
  assign state_o         = state_q;

endmodule
